i2c_passthru_mstr_arb_n: RTL



---
 rtl/i2c_passthru_mstr_arb_n.sv | 129 ++++++++++++
 1 files changed

// File: rtl/i2c_passthru_mstr_arb_n.sv
// N-channel I2C/SMBus master arbiter: grants ownership to one channel on START,
// holds it until STOP/idle, then enforces bus-free time; disconnects on violation/stuck.
module i2c_passthru_mstr_arb_n #(
  parameter int NUM_CH            = 4,
  parameter int WIDTH_CH          = 2,
  parameter int F_REF_T_BUF       = 38,
  parameter int WIDTH_F_REF_T_BUF = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_f_ref,
  input  logic [NUM_CH-1:0]   i_scl,
  input  logic [NUM_CH-1:0]   i_sda,
  input  logic [NUM_CH-1:0]   i_idle,
  input  logic [NUM_CH-1:0]   i_stuck,
  input  logic                i_violation,
  output logic [NUM_CH-1:0]   o_ismst,
  output logic [WIDTH_CH-1:0] o_mst_idx,
  output logic                o_mst_valid,
  output logic                o_disconnect,
  output logic                o_start_pulse,
  output logic                o_collision
);

  typedef enum logic [1:0] {ST_ARM, ST_OWN, ST_BUF, ST_DISC} state_t;

  localparam logic [NUM_CH-1:0]            ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_F_REF_T_BUF-1:0] BUF_MAX  = WIDTH_F_REF_T_BUF'(F_REF_T_BUF);

  state_t                       state, state_nxt;
  logic [NUM_CH-1:0]            prev_scl_p0, prev_sda_p0;
  logic [NUM_CH-1:0]            start, stop, mst_bit;
  logic [WIDTH_CH-1:0]          idx, idx_nxt, low_idx;
  logic [WIDTH_F_REF_T_BUF-1:0] cnt, cnt_nxt;
  logic                         spulse_nxt, coll_nxt, bus_high, multi_start;

  assign start       = prev_sda_p0 & ~i_sda & prev_scl_p0 & i_scl;
  assign stop        = ~prev_sda_p0 & i_sda & prev_scl_p0 & i_scl;
  assign bus_high    = (&i_scl) & (&i_sda);
  assign mst_bit     = ONE_HOT0 << idx;
  assign multi_start = (start & (start - ONE_HOT0)) != '0;

  // Lowest-index START wins when several channels start together
  always_comb begin
    low_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (start[k]) low_idx = WIDTH_CH'(k);
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    spulse_nxt = 1'b0;
    coll_nxt   = 1'b0;
    if (i_violation || (|i_stuck)) begin
      state_nxt = ST_DISC;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_ARM: begin
          if (|start) begin
            state_nxt  = ST_OWN;
            idx_nxt    = low_idx;
            spulse_nxt = 1'b1;
            coll_nxt   = multi_start;
          end
        end
        ST_OWN: begin
          coll_nxt = |(start & ~mst_bit);
          if (stop[idx] || i_idle[idx]) begin
            state_nxt = ST_BUF;
            idx_nxt   = '0;
            cnt_nxt   = '0;
          end else if (start[idx]) begin
            spulse_nxt = 1'b1;
          end
        end
        ST_BUF: begin
          coll_nxt = |start;
          if (!bus_high) begin
            cnt_nxt = '0;
          end else if (i_f_ref && (cnt < BUF_MAX)) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt_nxt == BUF_MAX) state_nxt = ST_ARM;
          end
        end
        ST_DISC: begin
          if (&i_idle) begin
            state_nxt = ST_BUF;
            cnt_nxt   = '0;
          end
        end
        default: state_nxt = ST_ARM;
      endcase
    end
  end

  // Registered state and outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_ARM;
      idx           <= '0;
      cnt           <= '0;
      prev_scl_p0   <= '1;
      prev_sda_p0   <= '1;
      o_ismst       <= '0;
      o_mst_valid   <= 1'b0;
      o_disconnect  <= 1'b0;
      o_start_pulse <= 1'b0;
      o_collision   <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      cnt           <= cnt_nxt;
      prev_scl_p0   <= i_scl;
      prev_sda_p0   <= i_sda;
      o_ismst       <= (state_nxt == ST_OWN) ? (ONE_HOT0 << idx_nxt) : '0;
      o_mst_valid   <= (state_nxt == ST_OWN);
      o_disconnect  <= (state_nxt == ST_DISC);
      o_start_pulse <= spulse_nxt;
      o_collision   <= coll_nxt;
    end
  end

  assign o_mst_idx = idx;

endmodule
